// File: rtl/button_bounce_gen.sv
// Contact-bounce waveform generator: press bounces, stable hold, release bounces, quiet gap, then done.
// Latency: btn_out rises one cycle after start is accepted. Backpressure: start is ignored while busy.
// BOUNCE_LFSR_EN selects LFSR-randomised segment widths; otherwise every segment is glitch_mask+1 cycles.
module button_bounce_gen #(
    parameter int          CNT_W = 16,
    parameter int          QUIET = 1000,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] hold_cycles,
    input  logic [CNT_W-1:0] glitch_mask,
    input  logic [3:0]       n_bounce,
    output logic             btn_out,
    output logic             busy,
    output logic             done,
    output logic [7:0]       edge_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_PRESS, S_HOLD, S_REL, S_QUIET} state_t;

    localparam logic [CNT_W-1:0] QUIET_M1 = CNT_W'(QUIET - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       seg_cnt, seg_nxt;
    logic [CNT_W-1:0] h_lat, h_nxt, m_lat, m_nxt;
    logic [3:0]       n_lat, n_nxt;
    logic             btn_nxt, busy_nxt, done_nxt;
    logic [7:0]       edge_nxt;

    // At acceptance the latches are not loaded yet, so the first segment and hold use the live inputs.
    logic [CNT_W-1:0] h_src, m_src, hold_m1, seg_m1;
    logic [4:0]       two_n;
    logic             seg_last;

    assign h_src    = (state == S_IDLE) ? hold_cycles : h_lat;
    assign m_src    = (state == S_IDLE) ? glitch_mask : m_lat;
    assign hold_m1  = (h_src == '0) ? '0 : h_src - CNT_W'(1);
    assign two_n    = {n_lat, 1'b0};
    assign seg_last = (seg_cnt == two_n - 5'd1);

`ifdef BOUNCE_LFSR_EN
    logic [15:0] lfsr;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= SEED;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
    end

    assign seg_m1 = CNT_W'(lfsr) & m_src;
`else
    assign seg_m1 = m_src;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        seg_nxt   = seg_cnt;
        h_nxt     = h_lat;
        m_nxt     = m_lat;
        n_nxt     = n_lat;
        btn_nxt   = btn_out;
        edge_nxt  = edge_cnt;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    h_nxt    = hold_cycles;
                    m_nxt    = glitch_mask;
                    n_nxt    = n_bounce;
                    btn_nxt  = 1'b1;
                    edge_nxt = 8'd1;
                    seg_nxt  = '0;
                    if (n_bounce != 4'd0) begin
                        state_nxt = S_PRESS;
                        cnt_nxt   = seg_m1;
                    end else begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = hold_m1;
                    end
                end
            end
            S_PRESS, S_REL: begin
                if (cnt == '0) begin
                    btn_nxt  = ~btn_out;
                    edge_nxt = edge_cnt + 8'd1;
                    if (seg_last) begin
                        seg_nxt = '0;
                        if (state == S_PRESS) begin
                            state_nxt = S_HOLD;
                            cnt_nxt   = hold_m1;
                        end else begin
                            state_nxt = S_QUIET;
                            cnt_nxt   = QUIET_M1;
                        end
                    end else begin
                        seg_nxt = seg_cnt + 5'd1;
                        cnt_nxt = seg_m1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    btn_nxt  = 1'b0;
                    edge_nxt = edge_cnt + 8'd1;
                    seg_nxt  = '0;
                    if (n_lat != 4'd0) begin
                        state_nxt = S_REL;
                        cnt_nxt   = seg_m1;
                    end else begin
                        state_nxt = S_QUIET;
                        cnt_nxt   = QUIET_M1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_QUIET: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            seg_cnt  <= '0;
            h_lat    <= '0;
            m_lat    <= '0;
            n_lat    <= '0;
            btn_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            seg_cnt  <= seg_nxt;
            h_lat    <= h_nxt;
            m_lat    <= m_nxt;
            n_lat    <= n_nxt;
            btn_out  <= btn_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            edge_cnt <= edge_nxt;
        end
    end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Directed bench for button_bounce_gen: two instances (QUIET=50 and QUIET=1) share inputs, own starts.
module tb_button_bounce_gen;
    logic        clk = 1'b0;
    logic        reset, start1, start2;
    logic [15:0] hold_cycles, glitch_mask;
    logic [3:0]  n_bounce;
    logic        btn1, busy1, done1, btn2, busy2, done2;
    logic [7:0]  edge1, edge2;

    int          sel;
    logic        mon_btn, mon_busy, mon_done;
    logic [7:0]  mon_edge;
    int          total = 0;
    int          bad = 0;
    logic        exp_q[$];
    logic        got_q[$];
    logic        ref_q[$];
    int          blen;

    always #5 clk = ~clk;

    button_bounce_gen #(.CNT_W(16), .QUIET(50)) dut_a (
        .clk(clk), .reset(reset), .start(start1), .hold_cycles(hold_cycles),
        .glitch_mask(glitch_mask), .n_bounce(n_bounce), .btn_out(btn1),
        .busy(busy1), .done(done1), .edge_cnt(edge1));

    button_bounce_gen #(.CNT_W(16), .QUIET(1)) dut_b (
        .clk(clk), .reset(reset), .start(start2), .hold_cycles(hold_cycles),
        .glitch_mask(glitch_mask), .n_bounce(n_bounce), .btn_out(btn2),
        .busy(busy2), .done(done2), .edge_cnt(edge2));

    assign mon_btn  = (sel != 0) ? btn2  : btn1;
    assign mon_busy = (sel != 0) ? busy2 : busy1;
    assign mon_done = (sel != 0) ? done2 : done1;
    assign mon_edge = (sel != 0) ? edge2 : edge1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_run(input logic v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic build_s1();
        exp_q.delete();
        push_run(1'b1, 4); push_run(1'b0, 4); push_run(1'b1, 4); push_run(1'b0, 4);
        push_run(1'b1, 100);
        push_run(1'b0, 4); push_run(1'b1, 4); push_run(1'b0, 4); push_run(1'b1, 4);
        push_run(1'b0, 50);
    endtask

    // Returns at the falling edge of the first busy cycle.
    task automatic go(input int n, input int m, input int h);
        @(negedge clk);
        n_bounce    = 4'(n);
        glitch_mask = 16'(m);
        hold_cycles = 16'(h);
        if (sel != 0) start2 = 1'b1;
        else          start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Records btn_out for every busy cycle; returns in the first non-busy cycle.
    task automatic capture(output int len);
        got_q.delete();
        len = 0;
        while (mon_busy === 1'b1 && len < 5000) begin
            got_q.push_back(mon_btn);
            len++;
            @(negedge clk);
        end
    endtask

    task automatic cmp_wave(input string tag);
        int mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        check({tag, "_diff"}, 32'(mism), 32'd0);
    endtask

    task automatic check_first(input string tag);
        check({tag, "_btn1"},  32'(mon_btn),  32'd1);
        check({tag, "_busy1"}, 32'(mon_busy), 32'd1);
        check({tag, "_edge1"}, 32'(mon_edge), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; sel = 0;
        hold_cycles = '0; glitch_mask = '0; n_bounce = '0;
        repeat (3) @(negedge clk);
        check("rst_btn",  32'(btn1),  32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_edge", 32'(edge1), 32'd0);
        reset = 1'b0;
`ifndef BOUNCE_LFSR_EN
        // Scenario 1: N=2, M=3, H=100
        go(2, 3, 100);
        check_first("s1");
        capture(blen);
        check("s1_busy_len", 32'(blen), 32'd182);
        build_s1();
        cmp_wave("s1");
        check("s1_edges", 32'(mon_edge), 32'd10);
        check("s1_done",  32'(mon_done), 32'd1);
        @(negedge clk);
        check("s1_done_once", 32'(mon_done), 32'd0);

        // A start during a request must not disturb it.
        go(2, 3, 100);
        fork
            capture(blen);
            begin
                repeat (19) @(negedge clk);
                n_bounce = 4'd0; glitch_mask = 16'd0; hold_cycles = 16'd1;
                start1 = 1'b1;
                @(negedge clk);
                start1 = 1'b0;
                check("ign_edge_kept", 32'(mon_edge), 32'd5);
            end
        join
        check("ign_busy_len", 32'(blen), 32'd182);
        cmp_wave("ign");
        check("ign_edges", 32'(mon_edge), 32'd10);

        // Reset during HOLD aborts without done.
        go(2, 3, 100);
        repeat (40) @(negedge clk);
        check("rh_in_hold", 32'(mon_btn), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rh_btn",  32'(mon_btn),  32'd0);
        check("rh_busy", 32'(mon_busy), 32'd0);
        check("rh_done", 32'(mon_done), 32'd0);
        check("rh_edge", 32'(mon_edge), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rh_no_done", 32'(mon_done), 32'd0);
        go(2, 3, 100);
        capture(blen);
        check("rh_busy_len", 32'(blen), 32'd182);
        cmp_wave("rh");
        check("rh_edges", 32'(mon_edge), 32'd10);

        // Scenario 2 on QUIET=1 instance: N=0, H=0 behaves as H=1.
        sel = 1;
        go(0, 5, 0);
        check_first("s2");
        capture(blen);
        check("s2_busy_len", 32'(blen), 32'd2);
        exp_q.delete();
        push_run(1'b1, 1); push_run(1'b0, 1);
        cmp_wave("s2");
        check("s2_edges", 32'(mon_edge), 32'd2);
        check("s2_done",  32'(mon_done), 32'd1);
        // Back-to-back: start in the done cycle is accepted.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check_first("btb");
        check("btb_done_low", 32'(mon_done), 32'd0);
        capture(blen);
        check("btb_busy_len", 32'(blen), 32'd2);
        check("btb_edges", 32'(mon_edge), 32'd2);
        check("btb_done",  32'(mon_done), 32'd1);
`else
        // LFSR build: N=3, M=7, H=20, two runs from reset must match.
        begin
            int runs[$];
            int run_len;
            go(3, 7, 20);
            check_first("l1");
            capture(blen);
            check("l1_edges", 32'(mon_edge), 32'd14);
            run_len = 1;
            for (int i = 1; i <= got_q.size(); i++) begin
                if (i == got_q.size() || got_q[i] !== got_q[i-1]) begin
                    runs.push_back(run_len);
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end
            check("l1_runs", 32'(runs.size()), 32'd14);
            if (runs.size() == 14) begin
                for (int i = 0; i < 14; i++) begin
                    if (i == 6)       check("l1_hold",  32'(runs[i]), 32'd20);
                    else if (i == 13) check("l1_quiet", 32'(runs[i]), 32'd50);
                    else check("l1_seg_range", 32'(runs[i] >= 1 && runs[i] <= 8), 32'd1);
                end
            end
            ref_q = got_q;
            reset = 1'b1;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            go(3, 7, 20);
            capture(blen);
            exp_q = ref_q;
            cmp_wave("l2_repeat");
            check("l2_edges", 32'(mon_edge), 32'd14);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
